// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one simple RAM port among N_REQ requesters, one
// transaction in flight. Define RAM_ARB_TIMEOUT_EN to add the response watchdog (TIMEOUT_CYC).
module ram_port_arbiter #(
   parameter int N_REQ       = 2,
   parameter int ADR_W       = 32,
   parameter int DAT_W       = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         io_req_ren,
   input  logic [N_REQ-1:0]         io_req_wen,
   input  logic [N_REQ*ADR_W-1:0]   io_req_adr,
   input  logic [N_REQ*DAT_W-1:0]   io_req_wdat,
   input  logic [N_REQ*DAT_W/8-1:0] io_req_wstrb,
   output logic [N_REQ-1:0]         io_req_gnt,
   output logic [N_REQ-1:0]         io_req_rvld,
   output logic [N_REQ-1:0]         io_req_free,
   output logic [N_REQ-1:0]         io_req_err,
   output logic [DAT_W-1:0]         io_req_rdat,
   output logic [ADR_W-1:0]         io_ram_adr,
   output logic                     io_ram_ren,
   output logic                     io_ram_wen,
   output logic [DAT_W/8-1:0]       io_ram_wstrb,
   output logic [DAT_W-1:0]         io_ram_wdat,
   input  logic [DAT_W-1:0]         io_ram_rdat,
   input  logic                     io_ram_rvld,
   input  logic                     io_ram_free
);

   localparam int STRB_W = DAT_W / 8;
   localparam int OWN_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RD_WAIT,
      ST_WR_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [OWN_W-1:0]    owner_q, owner_d;
   logic [OWN_W-1:0]    last_q, last_d;
   logic [ADR_W-1:0]    adr_q, adr_d;
   logic [DAT_W-1:0]    wdat_q, wdat_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                ren_q, ren_d;
   logic                wen_q, wen_d;
   logic                wr_op_q, wr_op_d;

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tmo_hit;

   assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC));
`endif

   logic                pick_vld;
   logic [OWN_W-1:0]    pick_idx;
   logic [OWN_W:0]      cand;
   logic [ADR_W-1:0]    sel_adr;
   logic [DAT_W-1:0]    sel_wdat;
   logic [STRB_W-1:0]   sel_wstrb;
   logic                sel_wr;

   // Scan requesters starting one past the last winner, wrapping modulo N_REQ.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, last_q} + (OWN_W+1)'(k);
         if (cand >= (OWN_W+1)'(N_REQ)) begin
            cand = cand - (OWN_W+1)'(N_REQ);
         end
         if (!pick_vld && (io_req_ren[cand[OWN_W-1:0]] || io_req_wen[cand[OWN_W-1:0]])) begin
            pick_vld = 1'b1;
            pick_idx = cand[OWN_W-1:0];
         end
      end
   end

   assign sel_adr   = io_req_adr[int'(pick_idx)*ADR_W +: ADR_W];
   assign sel_wdat  = io_req_wdat[int'(pick_idx)*DAT_W +: DAT_W];
   assign sel_wstrb = io_req_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
   // A simultaneous read+write request is treated as a write; the read is dropped.
   assign sel_wr    = io_req_wen[pick_idx];

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      wstrb_d     = wstrb_q;
      wr_op_d     = wr_op_q;
      ren_d       = 1'b0;
      wen_d       = 1'b0;
      io_req_gnt  = '0;
      io_req_rvld = '0;
      io_req_free = '0;
      io_req_err  = '0;
      io_req_rdat = '0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (pick_vld) begin
               io_req_gnt[pick_idx] = 1'b1;
               owner_d = pick_idx;
               last_d  = pick_idx;
               adr_d   = sel_adr;
               wdat_d  = sel_wdat;
               wstrb_d = sel_wstrb;
               wr_op_d = sel_wr;
               ren_d   = ~sel_wr;
               wen_d   = sel_wr;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = wr_op_q ? ST_WR_WAIT : ST_RD_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
            // The strobe cycle itself counts as the first elapsed cycle.
            cnt_d = CNT_W'(1);
`endif
         end
         ST_RD_WAIT: begin
            if (io_ram_rvld) begin
               io_req_rvld[owner_q] = 1'b1;
               io_req_rdat          = io_ram_rdat;
               state_d              = ST_IDLE;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               io_req_rvld[owner_q] = 1'b1;
               io_req_err[owner_q]  = 1'b1;
               state_d              = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_WR_WAIT: begin
            if (io_ram_free) begin
               io_req_free[owner_q] = 1'b1;
               state_d              = ST_IDLE;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               io_req_free[owner_q] = 1'b1;
               io_req_err[owner_q]  = 1'b1;
               state_d              = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (reset) begin
         io_req_gnt  = '0;
         io_req_rvld = '0;
         io_req_free = '0;
         io_req_err  = '0;
         io_req_rdat = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= OWN_W'(N_REQ - 1);
         adr_q   <= '0;
         wdat_q  <= '0;
         wstrb_q <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         wr_op_q <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         wstrb_q <= wstrb_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         wr_op_q <= wr_op_d;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign io_ram_adr   = adr_q;
   assign io_ram_wdat  = wdat_q;
   assign io_ram_wstrb = wstrb_q;
   assign io_ram_ren   = ren_q;
   assign io_ram_wen   = wen_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level model checked every cycle plus directed
// vectors with hand-computed expectations; the timeout scenario follows RAM_ARB_TIMEOUT_EN.
module tb_ram_port_arbiter;
   localparam int N   = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    io_req_ren = '0, io_req_wen = '0;
   logic [N*AW-1:0] io_req_adr = '0;
   logic [N*DW-1:0] io_req_wdat = '0;
   logic [N*SW-1:0] io_req_wstrb = '0;
   logic [N-1:0]    io_req_gnt, io_req_rvld, io_req_free, io_req_err;
   logic [DW-1:0]   io_req_rdat;
   logic [AW-1:0]   io_ram_adr;
   logic            io_ram_ren, io_ram_wen;
   logic [SW-1:0]   io_ram_wstrb;
   logic [DW-1:0]   io_ram_wdat;
   logic [DW-1:0]   io_ram_rdat;
   logic            io_ram_rvld, io_ram_free;

   ram_port_arbiter #(.N_REQ(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clock(clock), .reset(reset),
      .io_req_ren(io_req_ren), .io_req_wen(io_req_wen), .io_req_adr(io_req_adr),
      .io_req_wdat(io_req_wdat), .io_req_wstrb(io_req_wstrb),
      .io_req_gnt(io_req_gnt), .io_req_rvld(io_req_rvld), .io_req_free(io_req_free),
      .io_req_err(io_req_err), .io_req_rdat(io_req_rdat),
      .io_ram_adr(io_ram_adr), .io_ram_ren(io_ram_ren), .io_ram_wen(io_ram_wen),
      .io_ram_wstrb(io_ram_wstrb), .io_ram_wdat(io_ram_wdat),
      .io_ram_rdat(io_ram_rdat), .io_ram_rvld(io_ram_rvld), .io_ram_free(io_ram_free)
   );

   always #5 clock = ~clock;

   // RAM stand-in: answers a strobe one cycle later (echoing the address) while ram_auto is set.
   bit            ram_auto = 1'b1;
   logic          pend_rd = 1'b0, pend_wr = 1'b0;
   logic [AW-1:0] pend_adr = '0;
   logic          auto_rvld = 1'b0, auto_free = 1'b0;
   logic [DW-1:0] auto_rdat = '0;
   logic          frc_rvld = 1'b0, frc_free = 1'b0;
   logic [DW-1:0] frc_rdat = '0;

   always @(negedge clock) begin
      pend_rd  = io_ram_ren;
      pend_wr  = io_ram_wen;
      pend_adr = io_ram_adr;
   end
   always @(posedge clock) begin
      #2;
      auto_rvld = pend_rd & ram_auto;
      auto_free = pend_wr & ram_auto;
      auto_rdat = pend_adr;
   end
   assign io_ram_rvld = auto_rvld | frc_rvld;
   assign io_ram_free = auto_free | frc_free;
   assign io_ram_rdat = auto_rvld ? auto_rdat : frc_rdat;

   // Hand-computed expectations, each stamped with the cycle it applies to.
   int            cyc = 0;
   int            gnt_cyc = -1, rsp_cyc = -1, ram_cyc = -1, fld_cyc = -1;
   logic [N-1:0]  lit_gnt, lit_rvld, lit_free, lit_err;
   logic [DW-1:0] lit_rdat, lit_wdat;
   logic [AW-1:0] lit_adr;
   logic [SW-1:0] lit_wstrb;
   logic          lit_ren, lit_wen;

   task automatic exp_gnt(input logic [N-1:0] g);
      lit_gnt = g; gnt_cyc = cyc;
   endtask
   task automatic exp_rsp(input logic [N-1:0] rv, input logic [N-1:0] fr,
                          input logic [N-1:0] er, input logic [DW-1:0] rd);
      lit_rvld = rv; lit_free = fr; lit_err = er; lit_rdat = rd; rsp_cyc = cyc;
   endtask
   task automatic exp_ram(input logic r, input logic w);
      lit_ren = r; lit_wen = w; ram_cyc = cyc;
   endtask
   task automatic exp_fld(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      lit_adr = a; lit_wdat = d; lit_wstrb = s; fld_cyc = cyc;
   endtask

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
      end
   endtask

   // Behavioural model: one transaction at a time, round-robin from the last winner.
   int            m_phase = 0;   // 0 idle, 1 strobe cycle, 2 awaiting response
   int            m_last  = N - 1;
   int            m_owner = 0;
   int            m_since = 0;   // cycles elapsed since the strobe cycle
   bit            m_wr    = 1'b0;
   logic [AW-1:0] m_adr   = '0;
   logic [DW-1:0] m_wdat  = '0;
   logic [SW-1:0] m_wstrb = '0;
   logic          m_ren   = 1'b0, m_wen = 1'b0;

   always @(negedge clock) begin : cmp
      logic [N-1:0]  e_gnt, e_rvld, e_free, e_err;
      logic [DW-1:0] e_rdat;
      int            pick;
      bit            done;
      e_gnt = '0; e_rvld = '0; e_free = '0; e_err = '0; e_rdat = '0;
      pick = -1; done = 1'b0;

      if (!reset && m_phase == 0) begin
         for (int k = 1; k <= N; k++) begin
            if (pick < 0 && (io_req_ren[(m_last + k) % N] || io_req_wen[(m_last + k) % N]))
               pick = (m_last + k) % N;
         end
         if (pick >= 0) e_gnt[pick] = 1'b1;
      end
      if (!reset && m_phase == 2) begin
         if (!m_wr && io_ram_rvld) begin
            e_rvld[m_owner] = 1'b1; e_rdat = io_ram_rdat; done = 1'b1;
         end else if (m_wr && io_ram_free) begin
            e_free[m_owner] = 1'b1; done = 1'b1;
         end
`ifdef RAM_ARB_TIMEOUT_EN
         else if (m_since >= TMO) begin
            e_err[m_owner] = 1'b1;
            if (m_wr) e_free[m_owner] = 1'b1;
            else e_rvld[m_owner] = 1'b1;
            done = 1'b1;
         end
`endif
      end

      chk("gnt", 64'(io_req_gnt), 64'(e_gnt));
      chk("rvld", 64'(io_req_rvld), 64'(e_rvld));
      chk("free", 64'(io_req_free), 64'(e_free));
      chk("err", 64'(io_req_err), 64'(e_err));
      chk("rdat", 64'(io_req_rdat), 64'(e_rdat));
      chk("ram_ren", 64'(io_ram_ren), 64'(m_ren));
      chk("ram_wen", 64'(io_ram_wen), 64'(m_wen));
      chk("ram_adr", 64'(io_ram_adr), 64'(m_adr));
      chk("ram_wdat", 64'(io_ram_wdat), 64'(m_wdat));
      chk("ram_wstrb", 64'(io_ram_wstrb), 64'(m_wstrb));

      if (gnt_cyc == cyc) chk("lit_gnt", 64'(io_req_gnt), 64'(lit_gnt));
      if (rsp_cyc == cyc) begin
         chk("lit_rvld", 64'(io_req_rvld), 64'(lit_rvld));
         chk("lit_free", 64'(io_req_free), 64'(lit_free));
         chk("lit_err", 64'(io_req_err), 64'(lit_err));
         chk("lit_rdat", 64'(io_req_rdat), 64'(lit_rdat));
      end
      if (ram_cyc == cyc) begin
         chk("lit_ram_ren", 64'(io_ram_ren), 64'(lit_ren));
         chk("lit_ram_wen", 64'(io_ram_wen), 64'(lit_wen));
      end
      if (fld_cyc == cyc) begin
         chk("lit_ram_adr", 64'(io_ram_adr), 64'(lit_adr));
         chk("lit_ram_wdat", 64'(io_ram_wdat), 64'(lit_wdat));
         chk("lit_ram_wstrb", 64'(io_ram_wstrb), 64'(lit_wstrb));
      end

      if (reset) begin
         m_phase = 0; m_last = N - 1; m_owner = 0; m_since = 0; m_wr = 1'b0;
         m_adr = '0; m_wdat = '0; m_wstrb = '0; m_ren = 1'b0; m_wen = 1'b0;
      end else begin
         m_ren = 1'b0; m_wen = 1'b0;
         if (m_phase == 0 && pick >= 0) begin
            m_owner = pick; m_last = pick; m_wr = io_req_wen[pick];
            m_ren = !m_wr; m_wen = m_wr;
            m_adr = io_req_adr[pick*AW +: AW];
            m_wdat = io_req_wdat[pick*DW +: DW];
            m_wstrb = io_req_wstrb[pick*SW +: SW];
            m_phase = 1;
         end else if (m_phase == 1) begin
            m_phase = 2; m_since = 1;
         end else if (m_phase == 2) begin
            if (done) m_phase = 0;
            else m_since++;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset: outputs quiet even with a request pending.
      tick(); io_req_ren = 2'b01;
      exp_gnt('0); exp_rsp('0, '0, '0, '0); exp_ram(0, 0); exp_fld('0, '0, '0);
      tick(); reset = 1'b0; io_req_ren = '0;

      // Single read from requester 0.
      tick(); io_req_ren[0] = 1'b1; io_req_adr[31:0] = 32'h100; exp_gnt(2'b01);
      tick(); io_req_ren[0] = 1'b0; exp_gnt('0); exp_ram(1, 0); exp_fld(32'h100, '0, '0);
      exp_rsp('0, '0, '0, '0);
      tick(); exp_rsp(2'b01, '0, '0, 32'h100); exp_ram(0, 0);
      tick(); exp_rsp('0, '0, '0, '0);

      // Single write from requester 1.
      tick(); io_req_wen[1] = 1'b1; io_req_adr[63:32] = 32'h20; io_req_wdat[63:32] = 32'h3;
      io_req_wstrb[7:4] = 4'hF; exp_gnt(2'b10);
      tick(); io_req_wen[1] = 1'b0; exp_ram(0, 1); exp_fld(32'h20, 32'h3, 4'hF);
      tick(); exp_rsp('0, 2'b10, '0, '0);
      tick(); exp_rsp('0, '0, '0, '0);

      // Contention from reset: grants alternate 0,1,0,1 every three cycles.
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      io_req_adr[31:0] = 32'h10; io_req_adr[63:32] = 32'h14;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c == 0) io_req_ren = 2'b11;
         if (c % 3 == 0) exp_gnt(((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
         else exp_gnt('0);
         if (c == 2) exp_rsp(2'b01, '0, '0, 32'h10);
         if (c == 5) exp_rsp(2'b10, '0, '0, 32'h14);
      end
      tick(); io_req_ren = '0; exp_gnt('0);

      // Read and write together: only the write happens.
      tick(); io_req_ren[0] = 1'b1; io_req_wen[0] = 1'b1; io_req_adr[31:0] = 32'h44;
      io_req_wdat[31:0] = 32'hA5; io_req_wstrb[3:0] = 4'h1; exp_gnt(2'b01);
      tick(); io_req_ren = '0; io_req_wen = '0; exp_ram(0, 1); exp_fld(32'h44, 32'hA5, 4'h1);
      tick(); exp_rsp('0, 2'b01, '0, '0); exp_ram(0, 0);
      tick(); exp_rsp('0, '0, '0, '0); exp_gnt('0);

      // Spurious responses in idle and strobe cycles, free ignored while reading.
      ram_auto = 1'b0;
      tick(); frc_rvld = 1'b1; frc_free = 1'b1; frc_rdat = 32'hBAD; exp_rsp('0, '0, '0, '0);
      exp_gnt('0);
      tick(); frc_rvld = 1'b0; frc_free = 1'b0; io_req_ren[1] = 1'b1; io_req_adr[63:32] = 32'h200;
      exp_gnt(2'b10);
      tick(); io_req_ren = '0; frc_rvld = 1'b1; exp_ram(1, 0); exp_rsp('0, '0, '0, '0);
      tick(); frc_rvld = 1'b0; frc_free = 1'b1; exp_rsp('0, '0, '0, '0);
      tick(); frc_free = 1'b0; frc_rvld = 1'b1; frc_rdat = 32'h5A5A; exp_rsp(2'b10, '0, '0, 32'h5A5A);
      tick(); frc_rvld = 1'b0; exp_rsp('0, '0, '0, '0);

      // Reset while waiting for read data; the late response must be dropped.
      tick(); io_req_ren[0] = 1'b1; io_req_adr[31:0] = 32'h300; exp_gnt(2'b01);
      tick(); io_req_ren = '0; exp_ram(1, 0);
      tick(); exp_rsp('0, '0, '0, '0);
      tick(); reset = 1'b1; exp_rsp('0, '0, '0, '0); exp_gnt('0);
      tick(); reset = 1'b0; exp_fld('0, '0, '0);
      tick(); frc_rvld = 1'b1; frc_rdat = 32'h300; exp_rsp('0, '0, '0, '0);
      tick(); frc_rvld = 1'b0; ram_auto = 1'b1; io_req_ren[1] = 1'b1; io_req_adr[63:32] = 32'h304;
      exp_gnt(2'b10);
      tick(); io_req_ren = '0; exp_ram(1, 0); exp_fld(32'h304, 32'h3, 4'hF);
      tick(); exp_rsp(2'b10, '0, '0, 32'h304);
      tick(); exp_rsp('0, '0, '0, '0);

`ifdef RAM_ARB_TIMEOUT_EN
      // Silent RAM: error completion four cycles after the strobe.
      ram_auto = 1'b0;
      tick(); io_req_ren[0] = 1'b1; io_req_adr[31:0] = 32'h80; exp_gnt(2'b01);
      tick(); io_req_ren = '0; exp_ram(1, 0);
      tick(); exp_rsp('0, '0, '0, '0);
      tick(); exp_rsp('0, '0, '0, '0);
      tick(); exp_rsp('0, '0, '0, '0);
      tick(); exp_rsp(2'b01, '0, 2'b01, '0);
      tick(); exp_rsp('0, '0, '0, '0); exp_gnt('0);
      // A response landing on the expiry cycle completes normally.
      tick(); io_req_wen[1] = 1'b1; io_req_adr[63:32] = 32'h90; exp_gnt(2'b10);
      tick(); io_req_wen = '0; exp_ram(0, 1);
      tick(); tick(); tick();
      tick(); frc_free = 1'b1; exp_rsp('0, 2'b10, '0, '0);
      tick(); frc_free = 1'b0; exp_rsp('0, '0, '0, '0);
      ram_auto = 1'b1;
`else
      // Silent RAM without a watchdog: the arbiter keeps waiting and grants nobody else.
      ram_auto = 1'b0;
      tick(); io_req_ren[0] = 1'b1; io_req_adr[31:0] = 32'h80; exp_gnt(2'b01);
      tick(); io_req_ren = '0; exp_ram(1, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 5) io_req_ren[1] = 1'b1;
         exp_rsp('0, '0, '0, '0); exp_gnt('0);
      end
      tick(); io_req_ren = '0; reset = 1'b1;
      tick(); reset = 1'b0; ram_auto = 1'b1;
`endif

      tick(); exp_gnt('0);
      tick();
      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
